// File: rtl/pattern_source_sel.sv
// pattern_source_sel: colour-index source between the pixel feeder/VGA timing
// and the colour LUT. It tracks x/y/frame position from the timing strobes and
// picks either the memory pixel stream or a built-in test pattern for each
// pixel. The output is registered with one cycle of latency. A requested mode
// is taken only at frame_end, so a frame never tears.
module pattern_source_sel #(
  parameter int PIX_W     = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int FRAME_W   = 8,
  parameter int BAR_SHIFT = 3,
  parameter int CHK_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               display_enable,
  input  logic               line_end,
  input  logic               frame_end,
  input  logic [PIX_W-1:0]   mem_pixel,
  input  logic [2:0]         mode_req,
  output logic [2:0]         mode_active,
  output logic [PIX_W-1:0]   color_idx,
  output logic               color_valid,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [2:0] MODE_MEM   = 3'd0;
  localparam logic [2:0] MODE_FREE  = 3'd1;
  localparam logic [2:0] MODE_HBARS = 3'd2;
  localparam logic [2:0] MODE_VBARS = 3'd3;
  localparam logic [2:0] MODE_CHECK = 3'd4;
  localparam logic [2:0] MODE_ANIM  = 3'd5;
  localparam logic [2:0] MODE_SOLID = 3'd6;
  localparam logic [2:0] MODE_OFF   = 3'd7;

  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               line_seen_q, line_seen_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [PIX_W-1:0]   fc_q, fc_d;
  logic [2:0]         mode_q, mode_d;
  logic [PIX_W-1:0]   color_q, color_d;
  logic               valid_q, valid_d;

  // Pattern operands. Shifting before the cast zero-extends any slice that
  // runs past the top of the x or y counter.
  logic [PIX_W-1:0] hbar_s, vbar_s, pat_s;
  logic             chk_s;

  assign hbar_s = PIX_W'(x_q >> BAR_SHIFT);
  assign vbar_s = PIX_W'(y_q >> BAR_SHIFT);
  assign chk_s  = 1'(x_q >> CHK_SHIFT) ^ 1'(y_q >> CHK_SHIFT);

  // Next-state logic for the position counters, frame counter, free counter and mode.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    line_seen_d = line_seen_q;
    frame_d     = frame_q;
    fc_d        = fc_q + {{(PIX_W-1){1'b0}}, 1'b1};
    mode_d      = mode_q;

    // A strobe clears x even when the pixel is enabled in the same cycle.
    if (line_end || frame_end) begin
      x_d = '0;
    end else if (display_enable && (x_q != {X_W{1'b1}})) begin
      x_d = x_q + {{(X_W-1){1'b0}}, 1'b1};
    end else begin
      x_d = x_q;
    end

    // Lines with no visible pixel do not advance y.
    if (frame_end) begin
      y_d = '0;
    end else if (line_end && line_seen_q && (y_q != {Y_W{1'b1}})) begin
      y_d = y_q + {{(Y_W-1){1'b0}}, 1'b1};
    end else begin
      y_d = y_q;
    end

    if (line_end) begin
      line_seen_d = 1'b0;
    end else if (display_enable) begin
      line_seen_d = 1'b1;
    end else begin
      line_seen_d = line_seen_q;
    end

    if (frame_end) begin
      frame_d = frame_q + {{(FRAME_W-1){1'b0}}, 1'b1};
      mode_d  = mode_req;
    end else begin
      frame_d = frame_q;
      mode_d  = mode_q;
    end
  end

  // Select the pattern from the current, pre-increment position and the active mode.
  always_comb begin
    pat_s = '0;
    case (mode_q)
      MODE_MEM:   pat_s = mem_pixel;
      MODE_FREE:  pat_s = fc_q;
      MODE_HBARS: pat_s = hbar_s;
      MODE_VBARS: pat_s = vbar_s;
      MODE_CHECK: pat_s = {PIX_W{chk_s}};
      MODE_ANIM:  pat_s = hbar_s + frame_q[PIX_W-1:0];
      MODE_SOLID: pat_s = {PIX_W{1'b1}};
      MODE_OFF:   pat_s = {PIX_W{1'b0}};
      default:    pat_s = '0;
    endcase
  end

  // Blank the colour index outside the visible area, whatever the mode.
  always_comb begin
    valid_d = display_enable;
    if (display_enable) begin
      color_d = pat_s;
    end else begin
      color_d = '0;
    end
  end

  // State and output registers. Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      line_seen_q <= 1'b0;
      frame_q     <= '0;
      fc_q        <= '0;
      mode_q      <= MODE_MEM;
      color_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      line_seen_q <= line_seen_d;
      frame_q     <= frame_d;
      fc_q        <= fc_d;
      mode_q      <= mode_d;
      color_q     <= color_d;
      valid_q     <= valid_d;
    end
  end

  assign mode_active = mode_q;
  assign color_idx   = color_q;
  assign color_valid = valid_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_pattern_source_sel.sv
// Bench for pattern_source_sel: directed and random stimulus checked against
// an arithmetic model of the position counters and patterns, plus literal
// expectations at the notable points.
module tb_pattern_source_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0, le = 1'b0, fe = 1'b0;
  logic [3:0] mp = 4'd0;
  logic [2:0] mr = 3'd0;
  logic [2:0] mode_active;
  logic [3:0] color_idx;
  logic       color_valid;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model state, kept as plain integers.
  int mx, my, mseen, mframe, mfc, mmode, exp_color, exp_valid;

  pattern_source_sel dut (
    .clk(clk), .rst_n(rst_n), .display_enable(de), .line_end(le),
    .frame_end(fe), .mem_pixel(mp), .mode_req(mr), .mode_active(mode_active),
    .color_idx(color_idx), .color_valid(color_valid), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mx = 0; my = 0; mseen = 0; mframe = 0; mfc = 0; mmode = 0;
    exp_color = 0; exp_valid = 0;
  endtask

  function automatic int pattern(int mode, int pix);
    case (mode)
      0: return pix;
      1: return mfc;
      2: return (mx / 8) % 16;
      3: return (my / 8) % 16;
      4: return (((mx / 16) + (my / 16)) % 2 == 1) ? 15 : 0;
      5: return ((mx / 8) + mframe) % 16;
      6: return 15;
      default: return 0;
    endcase
  endfunction

  // One clock edge of the model, fed with the inputs present at the edge.
  task automatic model_step(int d, int l, int f, int pix, int req);
    exp_color = d ? pattern(mmode, pix) : 0;
    exp_valid = d;
    mfc = (mfc + 1) % 16;
    if (l || f) mx = 0;
    else if (d && mx < 1023) mx = mx + 1;
    if (f) my = 0;
    else if (l && mseen && my < 511) my = my + 1;
    if (l) mseen = 0;
    else if (d) mseen = 1;
    if (f) begin
      mframe = (mframe + 1) % 256;
      mmode = req;
    end
  endtask

  task automatic cyc(bit d, bit l, bit f, int pix, int req);
    de = d; le = l; fe = f; mp = 4'(pix); mr = 3'(req);
    @(posedge clk);
    model_step(d, l, f, pix, req);
    #1;
  endtask

  task automatic lit(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    rst_n = 1'b0;
    de = 1'b0; le = 1'b0; fe = 1'b0; mp = 4'd0; mr = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_en = 1'b1;
  endtask

  // Every-cycle comparison of DUT outputs against the model, on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if (color_idx != 4'(exp_color) || color_valid != 1'(exp_valid) ||
          mode_active != 3'(mmode) || frame_count != 8'(mframe)) begin
        n_bad++;
        $display("FAIL model t=%0t: idx=%0d valid=%0d mode=%0d frame=%0d expected idx=%0d valid=%0d mode=%0d frame=%0d",
                 $time, color_idx, color_valid, mode_active, frame_count,
                 exp_color, exp_valid, mmode, mframe);
      end
    end
  end

  initial begin
    model_reset();
    #2;
    // Reset state.
    lit("rst_idx", int'(color_idx), 0);
    lit("rst_valid", int'(color_valid), 0);
    lit("rst_mode", int'(mode_active), 0);
    lit("rst_frame", int'(frame_count), 0);
    do_reset();

    // 1: memory passthrough over a 640-pixel line.
    for (int i = 0; i < 640; i++) begin
      cyc(1'b1, 1'b0, 1'b0, i % 16, 0);
      if (i == 5) lit("t1_px5", int'(color_idx), 5);
      if (i == 639) lit("t1_valid_last", int'(color_valid), 1);
    end
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    lit("t1_blank", int'(color_valid), 0);

    // 2: HBARS requested mid-frame; it takes effect only after frame_end.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 3, 2);
    lit("t2_mode_held", int'(mode_active), 0);
    lit("t2_mem_still", int'(color_idx), 3);
    cyc(1'b0, 1'b1, 1'b1, 0, 2);
    lit("t2_mode_loaded", int'(mode_active), 2);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 9, 0);
      if (i == 7)   lit("t2_x7", int'(color_idx), 0);
      if (i == 8)   lit("t2_x8", int'(color_idx), 1);
      if (i == 128) lit("t2_x128", int'(color_idx), 0);
      if (i == 136) lit("t2_x136", int'(color_idx), 1);
    end
    cyc(1'b0, 1'b1, 1'b0, 0, 0);

    // 3: checkerboard on a 32x32 area with blank lines mixed in.
    cyc(1'b0, 1'b1, 1'b1, 0, 4);
    for (int l = 0; l < 32; l++) begin
      if (l % 4 == 0) cyc(1'b0, 1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 32; i++) begin
        cyc(1'b1, 1'b0, 1'b0, 5, 0);
        if (l == 0 && i == 0)   lit("t3_00", int'(color_idx), 0);
        if (l == 0 && i == 16)  lit("t3_x16", int'(color_idx), 15);
        if (l == 16 && i == 0)  lit("t3_y16", int'(color_idx), 15);
        if (l == 16 && i == 16) lit("t3_xy16", int'(color_idx), 0);
      end
      cyc(1'b0, 1'b1, 1'b0, 0, 0);
    end

    // 4: animated bars over three frames, then frame counter wrap.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 0, 5);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b0, 1'b0, 0, 5);
      lit("t4_anim_x0", int'(color_idx), 1 + f);
      cyc(1'b0, 1'b1, 1'b1, 0, 5);
    end
    lit("t4_frame4", int'(frame_count), 4);
    for (int f = 0; f < 251; f++) cyc(1'b0, 1'b0, 1'b1, 0, 5);
    lit("t4_frame255", int'(frame_count), 255);
    cyc(1'b0, 1'b0, 1'b1, 0, 2);
    lit("t4_wrap", int'(frame_count), 0);

    // 5: coincident strobes, then x saturation under continuous enable.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 0, 2);
    lit("t5_frame", int'(frame_count), 1);
    lit("t5_mode", int'(mode_active), 2);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    lit("t5_x0", int'(color_idx), 0);
    for (int i = 1; i < 1100; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    lit("t5_sat", int'(color_idx), 15);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);

    // 6: random timing, pixels and mode requests.
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 299) == 0), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 7)));
    end

    // 7: asynchronous reset mid-line in VBARS mode.
    cyc(1'b0, 1'b1, 1'b1, 0, 3);
    for (int l = 0; l < 12; l++) begin
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
      cyc(1'b0, 1'b1, 1'b0, 0, 0);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
    lit("t7_pre_mode", int'(mode_active), 3);
    lit("t7_pre_idx", int'(color_idx), 1);
    check_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    lit("t7_async_idx", int'(color_idx), 0);
    lit("t7_async_valid", int'(color_valid), 0);
    lit("t7_async_mode", int'(mode_active), 0);
    lit("t7_async_frame", int'(frame_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_en = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 12, 3);
    lit("t7_mode_after", int'(mode_active), 0);
    lit("t7_mem_after", int'(color_idx), 12);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
